// File: rtl/axis_layer_buffer.sv
// ---------------------------------------------------------------------------
// axis_layer_buffer
//   AXI4-Stream ingest buffer for the accelerator data path. A weight+bias
//   frame or an image frame is captured from the DMA into block RAM. Weights
//   and biases are then served through a 1-cycle random-access read port.
//   Images are replayed as an AXI4-Stream with full backpressure.
//
// Handshake rule (both stream ports): a beat transfers on a rising clk edge
//   where valid && ready are both high. A producer holds data/last stable
//   while valid is high and ready is low, and never drops valid before the
//   transfer.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   s_axis_tvalid/tready/tdata/tlast  ingest stream, tdata = {bias, word}
//   i_mode                         0 = weight frame, 1 = image frame (IDLE)
//   i_w_rd_en, i_w_rd_addr         weight/bias read strobe and address
//   o_w_data, o_b_data             registered weight / bias read data
//   o_w_rd_valid                   i_w_rd_en delayed by one cycle
//   m_axis_tvalid/tready/tdata/tlast  image replay stream
//   o_w_count, o_i_count           words stored by the last weight/image frame
//   o_w_loaded                     a complete weight set is held
//   o_overflow                     sticky: the current/last frame overran
//   o_state                        FSM state: 0 IDLE, 1 LOAD_W, 2 LOAD_I, 3 SEND
// ---------------------------------------------------------------------------
module axis_layer_buffer #(
  parameter int DATA_W  = 24,
  parameter int BIAS_W  = 8,
  parameter int W_DEPTH = 38016,
  parameter int B_DEPTH = 129,
  parameter int I_DEPTH = 49512,
  parameter int PTR_W   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_W+BIAS_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     i_mode,
  input  logic                     i_w_rd_en,
  input  logic [PTR_W-1:0]         i_w_rd_addr,
  output logic [DATA_W-1:0]        o_w_data,
  output logic [BIAS_W-1:0]        o_b_data,
  output logic                     o_w_rd_valid,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [PTR_W-1:0]         o_w_count,
  output logic [PTR_W-1:0]         o_i_count,
  output logic                     o_w_loaded,
  output logic                     o_overflow,
  output logic [1:0]               o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_I = 2'd2,
    SEND   = 2'd3
  } state_t;

  localparam int W_AW = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1;
  localparam int B_AW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int I_AW = (I_DEPTH > 1) ? $clog2(I_DEPTH) : 1;

  localparam logic [PTR_W-1:0] W_LIM = PTR_W'(W_DEPTH);
  localparam logic [PTR_W-1:0] B_LIM = PTR_W'(B_DEPTH);
  localparam logic [PTR_W-1:0] I_LIM = PTR_W'(I_DEPTH);
  localparam logic [PTR_W-1:0] ONE   = PTR_W'(1);

  logic [DATA_W-1:0] w_ram [W_DEPTH];
  logic [BIAS_W-1:0] b_ram [B_DEPTH];
  logic [DATA_W-1:0] i_ram [I_DEPTH];

  state_t state, state_nxt;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] depth_lim;
  logic [PTR_W-1:0] frame_cnt;
  logic             acc;
  logic             room;
  logic             last_acc;
  logic             start_w;
  logic             start_i;

  // Replay pipeline: p_* is the RAM output stage, m_* the output register.
  logic              p_valid;
  logic              p_last;
  logic [DATA_W-1:0] p_data;
  logic              m_valid;
  logic              m_last;
  logic [DATA_W-1:0] m_data;
  logic              issue;
  logic              move;
  logic              last_hs;

  logic [DATA_W-1:0] s_word;
  logic [BIAS_W-1:0] s_bias;

  assign s_word = s_axis_tdata[DATA_W-1:0];
  assign s_bias = s_axis_tdata[DATA_W+BIAS_W-1:DATA_W];

  assign s_axis_tready = (state == LOAD_W) || (state == LOAD_I);
  assign acc           = s_axis_tvalid && s_axis_tready;
  assign last_acc      = acc && s_axis_tlast;
  assign start_w       = (state == IDLE) && s_axis_tvalid && !i_mode;
  assign start_i       = (state == IDLE) && s_axis_tvalid && i_mode;

  // Once the pointer reaches the buffer depth, beats are accepted and
  // dropped; the pointer itself is the saturated beat count.
  assign depth_lim = (state == LOAD_I) ? I_LIM : W_LIM;
  assign room      = wr_ptr < depth_lim;
  assign frame_cnt = room ? (wr_ptr + ONE) : wr_ptr;

  // A read is issued whenever the RAM stage is empty or being drained this
  // cycle, so the RAM latency is hidden and steady state is one word/cycle.
  assign move    = p_valid && (!m_valid || m_axis_tready);
  assign issue   = (state == SEND) && (rd_ptr < o_i_count) && (!p_valid || move);
  assign last_hs = m_valid && m_axis_tready && m_last;

  assign m_axis_tvalid = m_valid;
  assign m_axis_tdata  = m_data;
  assign m_axis_tlast  = m_valid && m_last;
  assign o_state       = state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_axis_tvalid) state_nxt = i_mode ? LOAD_I : LOAD_W;
      LOAD_W:  if (last_acc)      state_nxt = IDLE;
      LOAD_I:  if (last_acc)      state_nxt = SEND;
      SEND:    if (last_hs)       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // ---------------- ingest bookkeeping ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      o_w_count  <= '0;
      o_i_count  <= '0;
      o_w_loaded <= 1'b0;
      o_overflow <= 1'b0;
    end else if (start_w || start_i) begin
      wr_ptr     <= '0;
      o_overflow <= 1'b0;
      if (start_w) o_w_loaded <= 1'b0;
    end else if (acc) begin
      if (room) wr_ptr     <= wr_ptr + ONE;
      else      o_overflow <= 1'b1;
      if (s_axis_tlast) begin
        if (state == LOAD_W) begin
          o_w_count  <= frame_cnt;
          o_w_loaded <= 1'b1;
        end else begin
          o_i_count  <= frame_cnt;
        end
      end
    end
  end

  // ---------------- block RAM write / image read ----------------
  always_ff @(posedge clk) begin
    if (acc && room && (state == LOAD_W)) begin
      w_ram[wr_ptr[W_AW-1:0]] <= s_word;
      if (wr_ptr < B_LIM) b_ram[wr_ptr[B_AW-1:0]] <= s_bias;
    end
    if (acc && room && (state == LOAD_I)) i_ram[wr_ptr[I_AW-1:0]] <= s_word;
    if (issue) p_data <= i_ram[rd_ptr[I_AW-1:0]];
  end

  // ---------------- image replay pipeline ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr  <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_data  <= '0;
    end else if (state == SEND) begin
      if (issue) begin
        rd_ptr <= rd_ptr + ONE;
        p_last <= (rd_ptr == (o_i_count - ONE));
      end
      if (issue)     p_valid <= 1'b1;
      else if (move) p_valid <= 1'b0;
      if (move) begin
        m_valid <= 1'b1;
        m_data  <= p_data;
        m_last  <= p_last;
      end else if (m_axis_tready) begin
        m_valid <= 1'b0;
      end
    end else begin
      rd_ptr  <= '0;
      p_valid <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

  // ---------------- weight/bias read port ----------------
  // No protection against reads during LOAD_W; data is whatever the RAM holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_w_rd_valid <= 1'b0;
      o_w_data     <= '0;
      o_b_data     <= '0;
    end else begin
      o_w_rd_valid <= i_w_rd_en;
      if (i_w_rd_en) begin
        o_w_data <= (i_w_rd_addr < W_LIM) ? w_ram[i_w_rd_addr[W_AW-1:0]] : '0;
        o_b_data <= (i_w_rd_addr < B_LIM) ? b_ram[i_w_rd_addr[B_AW-1:0]] : '0;
      end
    end
  end

endmodule

// File: doc/axis_layer_buffer.md
Name: axis_layer_buffer

Overview:
- Parametrised AXI4-Stream ingest buffer for the accelerator data path.
- Captures a weight+bias frame or an image frame from the DMA into on-chip block RAM, then serves it to compute:
  - weights/bias through a 1-cycle random-access read port;
  - images as an AXI4-Stream replay with full valid/ready backpressure.
- Adds frame-length capture, overflow detection and tlast-qualified completion.

Parameters:
DATA_W, 24, width of weight/image word (s_axis_tdata[DATA_W-1:0])
BIAS_W, 8, width of bias byte (s_axis_tdata[DATA_W+BIAS_W-1:DATA_W])
W_DEPTH, 38016, weight buffer entries
B_DEPTH, 129, bias buffer entries (written from the first B_DEPTH beats of a weight frame)
I_DEPTH, 49512, image buffer entries
PTR_W, 16, pointer/count width; must satisfy 2^PTR_W > max(W_DEPTH, I_DEPTH)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  input stream valid
s_axis_tready  out  1  input stream ready
s_axis_tdata  in  DATA_W+BIAS_W  {bias, word}
s_axis_tlast  in  1  end of frame
i_mode  in  1  0 = weight frame, 1 = image frame; sampled in IDLE
i_w_rd_en  in  1  weight/bias read strobe
i_w_rd_addr  in  PTR_W  weight/bias read address
o_w_data  out  DATA_W  weight read data
o_b_data  out  BIAS_W  bias read data (0 when addr >= B_DEPTH)
o_w_rd_valid  out  1  read data valid, 1 cycle after i_w_rd_en
m_axis_tvalid  out  1  image replay valid
m_axis_tready  in  1  image replay ready
m_axis_tdata  out  DATA_W  image replay data
m_axis_tlast  out  1  last image word
o_w_count  out  PTR_W  words stored by last weight frame
o_i_count  out  PTR_W  words stored by last image frame
o_w_loaded  out  1  weight set valid
o_overflow  out  1  sticky: a frame exceeded its buffer depth
o_state  out  2  current state (for LEDs/debug)

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all pointers and counts = 0; every output = 0.
  - RAM contents are not reset.
  - Reset mid-frame or mid-replay aborts immediately; o_w_loaded = 0.
- States:
  - IDLE = 0: tready = 0. On s_axis_tvalid go to LOAD_W (i_mode = 0) or LOAD_I (i_mode = 1). No beat is consumed in IDLE.
  - LOAD_W = 1: tready = 1. Entry clears wr_ptr, o_w_loaded and o_overflow.
  - LOAD_I = 2: tready = 1. Entry clears wr_ptr and o_overflow.
  - SEND = 3: tready = 0.
- Beat accept: acc = tvalid && tready.
  - LOAD_W: word → w_ram[wr_ptr]; bias → b_ram[wr_ptr] only if wr_ptr < B_DEPTH.
  - LOAD_I: word → i_ram[wr_ptr].
  - wr_ptr increments per acc.
- Overflow:
  - Once wr_ptr == depth, further beats are still accepted (stream never stalls) but are discarded.
  - wr_ptr saturates at depth; o_overflow = 1 until the next frame starts.
- Completion is qualified by acc && tlast only; tlast without valid is ignored.
  - LOAD_W: o_w_count = saturated beat count, o_w_loaded = 1, next state IDLE.
  - LOAD_I: o_i_count = saturated count, next state SEND.
- SEND:
  - Replays i_ram[0 .. o_i_count-1] in order.
  - Uses a 1-entry output register plus prefetch so the RAM 1-cycle latency is hidden.
  - First m_axis_tvalid no later than 2 cycles after entering SEND.
  - One word/cycle while m_axis_tready stays high.
  - m_axis_tdata/tlast hold stable while tvalid && !tready.
  - m_axis_tlast = 1 on word o_i_count-1 only.
  - After the tlast handshake: tvalid = 0 and next state IDLE the following cycle.
- Weight read port:
  - Active in every state, including during LOAD_W; data is then undefined, no hazard protection.
  - o_w_data/o_b_data registered; o_w_rd_valid = i_w_rd_en delayed 1 cycle.
  - Address >= W_DEPTH returns 0.
- Counts/flags hold between frames; o_state mirrors state.

Test Plan:
- Weight frame of 200 beats, tdata = {i[7:0], i+0x1000}, tlast on beat 199 → o_w_count = 200, o_w_loaded = 1; read addr 5 → o_w_data = 0x001005, o_b_data = 0x05 next cycle; addr 150 → o_b_data = 0, o_w_data = 0x001096.
- Image frame of 16 beats, values 0..15, m_axis_tready = 1 → replay of 0..15 on 16 consecutive cycles, tlast with 15, then IDLE.
- Same 16-beat frame, m_axis_tready toggling 1-0-0-1 → data stable during stalls, sequence 0..15 unbroken, exactly 16 handshakes.
- Weight frame of W_DEPTH+3 beats (use W_DEPTH = 64) → all 67 beats accepted, o_w_count = 64, o_overflow = 1; next image frame start → o_overflow = 0.
- tlast high with tvalid low mid-frame, then 4 more beats with tlast on the last → frame not ended early, count = original beats + 4.
- rstn asserted at beat 10 of an image frame and mid-SEND → immediate IDLE, m_axis_tvalid = 0, counts = 0, o_w_loaded = 0; new weight frame loads correctly afterwards.
